// File: rtl/nonsym_read_engine.sv
// nonsym_read_engine: width-converting read FIFO between a wide pattern
// generator and a narrow pipe-out, with run control and cycle timing.
module nonsym_read_engine #(
  parameter int IN_WIDTH     = 64,
  parameter int OUT_WIDTH    = 32,
  parameter int DEPTH        = 2048,
  parameter int AFULL_MARGIN = 4,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 flush,
  input  logic                 word_order,
  input  logic [31:0]          xfer_limit,
  input  logic [IN_WIDTH-1:0]  gen_data,
  input  logic                 gen_valid,
  output logic                 gen_enable,
  input  logic                 rd_en,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] clk_counts,
  output logic [31:0]          words_read,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  localparam logic [PW-1:0] RATIO_P = PW'(RATIO);
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_MARGIN * RATIO);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [OUT_WIDTH-1:0] slice [RATIO];

  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [PW-1:0]        occ;
  logic [PW-1:0]        free;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          rd_cnt_q, rd_cnt_d;
  logic [31:0]          wr_cnt_q, wr_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic wr_ok;
  logic rd_ok;
  logic go;
  logic halt;
  logic limit_hit;
  logic running;

  // Extra pointer bit lets occ reach DEPTH without aliasing to empty
  always_comb begin
    occ  = wptr_q - rptr_q;
    free = DEPTH_P - occ;
  end

  assign empty       = (occ == '0);
  assign almost_full = (free < AFULL_P);
  assign running     = (state_q == RUN);
  assign busy        = running;
  assign done        = (state_q == DONE);

  assign wr_ok = gen_valid & ~flush & (free >= RATIO_P);
  assign rd_ok = rd_en & ~flush & ~empty;
  assign go    = start & ~stop & ~flush;
  assign halt  = stop & ~flush & running;

  assign limit_hit = running & rd_ok
                   & (xfer_limit != '0)
                   & ((rd_cnt_q + 32'd1) == xfer_limit);

  assign gen_enable = running & ~almost_full
                    & ((xfer_limit == '0)
                    | (wr_cnt_q < xfer_limit));

  assign dout       = dout_q;
  assign clk_counts = cnt_q;
  assign words_read = rd_cnt_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

  // slice[0] is the first one the host will see
  always_comb begin
    for (int i = 0; i < RATIO; i++) begin
      if (word_order) begin
        slice[i] = gen_data[i*OUT_WIDTH +: OUT_WIDTH];
      end else begin
        slice[i] = gen_data[(RATIO-1-i)*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = DONE;
    end else if (go) begin
      state_d = RUN;
    end else if (limit_hit) begin
      state_d = DONE;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (go) begin
      cnt_d    = '0;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (running) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      if (running & rd_ok) begin
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
      if (wr_ok) begin
        wr_cnt_d = wr_cnt_q + 32'(RATIO);
      end
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    dout_d = dout_q;
    ovf_d  = ovf_q | (gen_valid & (free < RATIO_P));
    udf_d  = udf_q | (rd_en & empty);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (wr_ok) begin
        wptr_d = wptr_q + RATIO_P;
      end
      if (rd_ok) begin
        rptr_d = rptr_q + PW'(1);
        dout_d = mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < RATIO; i++) begin
        mem_q[wptr_q[AW-1:0] + AW'(i)] <= slice[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

endmodule

// File: tb/tb_nonsym_read_engine.sv
// tb_nonsym_read_engine: directed bench with a queue-level reference
// model for the default build plus a RATIO=1 wrap check.
module tb_nonsym_read_engine;

  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, stop, flush, word_order;
  logic        gen_valid, rd_en;
  logic [31:0] xfer_limit;
  logic [63:0] gen_data;
  logic        gen_enable, empty, almost_full, busy, done;
  logic        overflow, underflow;
  logic [31:0] dout, words_read;
  logic [63:0] clk_counts;

  logic        r1_valid, r1_rd;
  logic [31:0] r1_data, r1_dout, r1_wr;
  logic        r1_gen_en, r1_empty, r1_af, r1_busy, r1_done;
  logic        r1_ovf, r1_udf;
  logic [63:0] r1_cnt;

  nonsym_read_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .flush(flush), .word_order(word_order), .xfer_limit(xfer_limit),
    .gen_data(gen_data), .gen_valid(gen_valid),
    .gen_enable(gen_enable), .rd_en(rd_en), .dout(dout),
    .empty(empty), .almost_full(almost_full), .busy(busy),
    .done(done), .clk_counts(clk_counts), .words_read(words_read),
    .overflow(overflow), .underflow(underflow)
  );

  nonsym_read_engine #(
    .IN_WIDTH(32), .OUT_WIDTH(32), .DEPTH(16)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .start(1'b0), .stop(1'b0),
    .flush(1'b0), .word_order(1'b0), .xfer_limit(32'd0),
    .gen_data(r1_data), .gen_valid(r1_valid),
    .gen_enable(r1_gen_en), .rd_en(r1_rd), .dout(r1_dout),
    .empty(r1_empty), .almost_full(r1_af), .busy(r1_busy),
    .done(r1_done), .clk_counts(r1_cnt), .words_read(r1_wr),
    .overflow(r1_ovf), .underflow(r1_udf)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue of narrow words, run state as int
  int          m_state;
  logic [31:0] m_q[$];
  logic [31:0] m_dout, m_wr, m_written;
  logic [63:0] m_cnt;
  bit          m_ovf, m_und;

  always @(posedge clk) begin : model
    int free;
    bit pop, push, go;
    if (!reset_n) begin
      m_state = 0; m_q.delete(); m_dout = 0; m_wr = 0;
      m_written = 0; m_cnt = 0; m_ovf = 0; m_und = 0;
    end else begin
      free = DEPTH - m_q.size();
      pop  = rd_en && !flush && m_q.size() != 0;
      push = gen_valid && !flush && free >= 2;
      go   = start && !stop && !flush;
      if (flush) begin
        m_q.delete(); m_ovf = 0; m_und = 0;
      end else begin
        if (gen_valid && free < 2) m_ovf = 1;
        if (rd_en && m_q.size() == 0) m_und = 1;
      end
      if (pop) m_dout = m_q.pop_front();
      if (push) begin
        if (word_order) begin
          m_q.push_back(gen_data[31:0]);
          m_q.push_back(gen_data[63:32]);
        end else begin
          m_q.push_back(gen_data[63:32]);
          m_q.push_back(gen_data[31:0]);
        end
      end
      if (go) begin
        m_cnt = 0; m_wr = 0; m_written = 0; m_state = 1;
      end else begin
        if (m_state == 1) begin
          m_cnt++;
          if (pop) m_wr++;
        end
        if (push) m_written += 2;
        if (!flush && m_state == 1 &&
            (stop || (pop && xfer_limit != 0 && m_wr == xfer_limit)))
          m_state = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", 64'(dout), 64'(m_dout));
      chk("empty", 64'(empty), 64'(m_q.size() == 0));
      chk("almost_full", 64'(almost_full), 64'((DEPTH - m_q.size()) < 8));
      chk("busy", 64'(busy), 64'(m_state == 1));
      chk("done", 64'(done), 64'(m_state == 2));
      chk("gen_enable", 64'(gen_enable),
          64'(m_state == 1 && (DEPTH - m_q.size()) >= 8 &&
              (xfer_limit == 0 || m_written < xfer_limit)));
      chk("clk_counts", clk_counts, m_cnt);
      chk("words_read", 64'(words_read), 64'(m_wr));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_und));
    end
  end

  logic [63:0] w [4] = '{64'h00000001_00000002, 64'h00000003_00000004,
                         64'h00000005_00000006, 64'h00000007_00000008};
  logic [31:0] e_msb [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  logic [31:0] e_lsb [8] = '{2, 1, 4, 3, 6, 5, 8, 7};

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_xfer(input string nm, input logic [31:0] exp [8]);
    int idx, npop;
    bit pend;
    idx = 0; npop = 0; pend = 1'b0;
    pulse_start();
    for (int c = 0; c < 60 && npop < 8; c++) begin
      if (pend) begin
        chk(nm, 64'(dout), 64'(exp[npop]));
        npop++;
      end
      gen_valid = gen_enable && idx < 4;
      gen_data  = (idx < 4) ? w[idx] : 64'd0;
      if (gen_valid) idx++;
      pend  = !empty && !done;
      rd_en = pend;
      tick();
    end
    gen_valid = 1'b0; rd_en = 1'b0;
    chk({nm, " pops"}, 64'(npop), 64'd8);
  endtask

  initial begin
    int n;
    logic [31:0] r1_q[$];
    logic [31:0] r1_exp;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; flush = 1'b0;
    word_order = 1'b0; gen_valid = 1'b0; rd_en = 1'b0;
    xfer_limit = 32'd0; gen_data = 64'd0;
    r1_valid = 1'b0; r1_rd = 1'b0; r1_data = 32'd0;
    tick(); tick();
    reset_n = 1'b1;
    chk_en = 1'b1;
    chk("rst dout", 64'(dout), 64'd0);
    chk("rst empty", 64'(empty), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst gen_enable", 64'(gen_enable), 64'd0);

    // MSB-first transfer with limit 8
    xfer_limit = 32'd8;
    run_xfer("msb dout", e_msb);
    chk("msb done", 64'(done), 64'd1);
    chk("msb words_read", 64'(words_read), 64'd8);
    chk("msb clk_counts", clk_counts, 64'd9);
    tick(); tick(); tick();
    chk("msb clk frozen", clk_counts, 64'd9);

    // LSB-first transfer
    word_order = 1'b1;
    run_xfer("lsb dout", e_lsb);
    chk("lsb done", 64'(done), 64'd1);
    chk("lsb overflow", 64'(overflow), 64'd0);
    chk("lsb underflow", 64'(underflow), 64'd0);
    word_order = 1'b0;

    // Fill to almost_full, then force overflow
    xfer_limit = 32'd0;
    pulse_start();
    n = 0;
    for (int c = 0; c < 1100; c++) begin
      gen_valid = gen_enable;
      gen_data  = {32'(2*c), 32'(2*c+1)};
      if (!gen_enable) break;
      n++;
      tick();
    end
    gen_valid = 1'b0;
    chk("fill words", 64'(n), 64'd1021);
    chk("fill almost_full", 64'(almost_full), 64'd1);
    chk("fill gen_enable", 64'(gen_enable), 64'd0);
    for (int k = 0; k < 5; k++) begin
      gen_valid = 1'b1;
      gen_data  = {32'(k), 32'hdead_0000 | 32'(k)};
      tick();
    end
    gen_valid = 1'b0;
    chk("full overflow", 64'(overflow), 64'd1);
    chk("full model size", 64'(m_q.size()), 64'd2048);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush empty", 64'(empty), 64'd1);
    chk("flush overflow", 64'(overflow), 64'd0);
    chk("flush busy", 64'(busy), 64'd1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Underflow and reset
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("udf flag", 64'(underflow), 64'd1);
    chk("udf dout", 64'(dout), 64'd0);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("rst2 underflow", 64'(underflow), 64'd0);
    chk("rst2 done", 64'(done), 64'd0);
    chk("rst2 empty", 64'(empty), 64'd1);

    // Timed run, stop wins over start
    pulse_start();
    repeat (99) tick();
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk("timed done", 64'(done), 64'd1);
    chk("timed clk_counts", clk_counts, 64'd100);
    tick(); tick();
    chk("timed hold", clk_counts, 64'd100);
    pulse_start();
    chk("restart clear", clk_counts, 64'd0);
    tick(); tick(); tick();
    chk("restart count", clk_counts, 64'd3);
    stop = 1'b1; tick(); stop = 1'b0;

    // RATIO=1 build: steady write+read across pointer wrap
    for (int i = 0; i < 5; i++) begin
      r1_valid = 1'b1; r1_data = 32'(i + 1);
      r1_q.push_back(r1_data);
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      r1_valid = 1'b1; r1_rd = 1'b1;
      r1_data  = 32'(100 + c);
      r1_exp   = r1_q.pop_front();
      r1_q.push_back(r1_data);
      tick();
      chk("r1 dout", 64'(r1_dout), 64'(r1_exp));
      chk("r1 empty", 64'(r1_empty), 64'd0);
      chk("r1 almost_full", 64'(r1_af), 64'd0);
    end
    r1_valid = 1'b0; r1_rd = 1'b0;
    tick();
    chk("r1 overflow", 64'(r1_ovf), 64'd0);
    chk("r1 underflow", 64'(r1_udf), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nonsym_read_engine.md
# nonsym_read_engine

Parametrised read-benchmark engine: accepts wide words from the pattern generator, buffers them in an internal width-converting FIFO, and serves narrow words to the host pipe-out endpoint. It also measures transfer time in clock cycles. Relative to the fixed 64→32 test top, it adds configurable width ratio, depth and slice order, an optional transfer-length limit with automatic stop, a run state machine, and sticky overflow/underflow diagnostics. It sits between the data generator and the host pipe-out/wire-out endpoints.

## Interface
- IN_WIDTH, 64, generator word width; must equal RATIO*OUT_WIDTH with RATIO in {1,2,4,8}
- OUT_WIDTH, 32, pipe-out word width
- DEPTH, 2048, FIFO capacity in OUT_WIDTH words; power of two, ≥ 8*RATIO
- AFULL_MARGIN, 4, free space (in IN_WIDTH words) below which almost_full asserts
- CNT_WIDTH, 64, cycle-counter width
- clk  in  1  host interface clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle trigger: clear counters, enter RUN
- stop  in  1  single-cycle trigger: end RUN
- flush  in  1  single-cycle trigger: empty FIFO, clear sticky flags
- word_order  in  1  0: most-significant OUT_WIDTH slice read first; 1: least-significant first
- xfer_limit  in  32  output words to transfer per run; 0 = unlimited
- gen_data  in  IN_WIDTH  generator word
- gen_valid  in  1  gen_data valid this cycle
- gen_enable  out  1  request to generator
- rd_en  in  1  pipe-out read strobe
- dout  out  OUT_WIDTH  read data
- empty, almost_full  out  1  FIFO status
- busy  out  1  state == RUN
- done  out  1  state == DONE
- clk_counts  out  CNT_WIDTH  cycles spent in RUN
- words_read  out  32  output words read this run
- overflow, underflow  out  1  sticky error flags

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + start → RUN. On the start cycle, clk_counts, words_read and the written-word count are set to 0.
- RUN + stop → DONE.
- RUN → DONE on the cycle words_read becomes xfer_limit (xfer_limit ≠ 0).
- start in RUN restarts the run: counters clear and state stays RUN.
- Priority: reset_n low > flush > stop > start. start and stop together: stop wins.
- flush clears FIFO pointers, overflow and underflow. It does not change state or counters.
- Counter: clk_counts increments by 1 on every RUN cycle after the start cycle. It holds in IDLE/DONE and wraps modulo 2^CNT_WIDTH.
- gen_enable = busy & ~almost_full & (xfer_limit == 0 | written < xfer_limit). written counts OUT_WIDTH words, advancing by RATIO per accepted write.
- Write: gen_valid with free ≥ RATIO stores one IN_WIDTH word as RATIO slices, ordered per word_order (sampled at write).
  - gen_valid with free < RATIO drops the whole word and sets overflow.
  - gen_valid is accepted in any state.
- Read: rd_en with FIFO not empty pops one slice. rd_en while empty sets underflow; dout and pointers hold.
- Counts: words_read increments per successful pop, only while in RUN or on the RUN→DONE cycle.
- Occupancy: simultaneous write and read change occupancy by RATIO−1.
- almost_full = free < AFULL_MARGIN*RATIO. empty = occupancy == 0.

## Timing
- Reset values: state IDLE, gen_enable 0, dout 0, empty 1, almost_full 0, busy 0, done 0, clk_counts 0, words_read 0, overflow 0, underflow 0.
- Read latency: dout updates on the clock edge after the rd_en cycle (block-RAM style) and holds until the next pop.
- Write-to-empty latency: empty deasserts 1 cycle after the accepting edge.
- Status flags: almost_full, empty, busy, done and gen_enable are registered or decoded from registered state, with no combinational path from rd_en.
- Limit edge: the pop that makes words_read == xfer_limit moves the state to DONE on the same edge; busy is 0 on the next cycle.
- Pointers wrap modulo DEPTH. Full is distinguished from empty by an extra pointer bit.
- Reset or flush mid-transfer: the FIFO is empty on the next cycle and any in-flight generator word arriving afterwards is written normally.

## Test plan
- Defaults, word_order=0, xfer_limit=8, start, generator sends 0x00000001_00000002 and 0x00000003_00000004, continuous rd_en → dout sequence 1,2,3,4,…; done asserts after the 8th pop; words_read=8; clk_counts frozen.
- word_order=1, same data → dout 2,1,4,3; no overflow/underflow.
- xfer_limit=0, no reads, generator always valid → gen_enable drops when free < 8. Then force gen_valid on 5 more words → FIFO full at 2048, overflow=1, excess words dropped. flush → empty=1, overflow=0.
- rd_en on empty FIFO after reset → underflow=1, dout stays 0. Assert reset_n low for one cycle → all outputs return to reset values.
- start, run 100 cycles, stop with simultaneous start → DONE, clk_counts=100. A later start → clk_counts cleared to 0 and counting again.
- RATIO=1 build (IN_WIDTH=OUT_WIDTH=32, DEPTH=16) with simultaneous write/read every cycle → occupancy constant; pointers wrap past 16 without data loss.
